// File: rtl/control_fsm_pkg.sv
// Shared types, opcodes and select encodings for the multicycle control FSM.
// CTRL_TRAP_EN (optional) enables the TRAP state and sticky illegal flag.
package control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SRA = 3'b111
    } alu_ctl_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_src_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10
    } alu_op_t;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        alu_op_t    alu_op;
    } ctrl_t;

    // Moore part of the output decode; unnamed fields stay zero.
    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        unique case (s)
            S_FETCH: begin
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.result_src = RES_ALUOUT;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_WDATA;
                c.alu_op    = AOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_REG;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = AOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a  = SRCA_REG;
                c.alu_src_b  = SRCB_WDATA;
                c.alu_op     = AOP_SUB;
                c.result_src = RES_ALUOUT;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_LUI: begin
                c.alu_src_a = SRCA_ZERO;
                c.alu_src_b = SRCB_IMM;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic alu_legal(logic       op_5,
                                       logic [2:0] funct3,
                                       logic [6:0] funct7);
        logic f7_zero;
        logic f7_alt;
        logic ok;
        f7_zero = (funct7 == 7'b0000000);
        f7_alt  = (funct7 == 7'b0100000);
        unique case (funct3)
            3'b000:  ok = !op_5 || f7_zero || f7_alt;
            3'b101:  ok = f7_zero || f7_alt;
            3'b010,
            3'b100,
            3'b110,
            3'b111:  ok = !op_5 || f7_zero;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Instruction fields in, datapath strobes/selects out, for control_fsm.
// The illegal flag exists only when CTRL_TRAP_EN is defined.
interface control_fsm_if;

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        Zero;

    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [2:0]  ImmSrc;
    logic [31:0] instret;
`ifdef CTRL_TRAP_EN
    logic        illegal;

    modport master (
        input  op, funct3, funct7, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
        output instret, illegal
    );

    modport slave (
        output op, funct3, funct7, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
        input  instret, illegal
    );
`else
    modport master (
        input  op, funct3, funct7, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
        output instret
    );

    modport slave (
        output op, funct3, funct7, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
        input  instret
    );
`endif

endinterface

// File: rtl/control_fsm_alu_decoder.sv
// Combinational ALUControl decode from ALUOp class and instruction fields.
module alu_decoder
    import control_fsm_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       op_5,
    output alu_ctl_t   alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        unique case (alu_op)
            AOP_SUB: alu_control = ALU_SUB;
            AOP_FUNCT: begin
                unique case (funct3)
                    // funct7[5] on an I-type add is immediate data, not sub
                    3'b000: begin
                        if (op_5 && funct7_5) alu_control = ALU_SUB;
                        else                  alu_control = ALU_ADD;
                    end
                    3'b010: alu_control = ALU_SLT;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: begin
                        if (funct7_5) alu_control = ALU_SRA;
                        else          alu_control = ALU_SRL;
                    end
                    3'b110: alu_control = ALU_OR;
                    3'b111: alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32 control FSM with registered Moore strobes and instret.
// CTRL_TRAP_EN: illegal instructions lock in TRAP and raise illegal.
module control_fsm
    import control_fsm_pkg::*;
(
    input  logic         clk,
    input  logic         resetn,
    control_fsm_if.master bus
);

`ifdef CTRL_TRAP_EN
    localparam state_t ILL_ST = S_TRAP;
`else
    localparam state_t ILL_ST = S_FETCH;
`endif

    state_t      state;
    state_t      nxt;
    ctrl_t       ctrl;
    logic        run;
    logic        legal;
    logic        retire;
    logic        br_take;
    logic [31:0] instret;
    imm_src_t    imm_src;
    alu_ctl_t    alu_ctl;
`ifdef CTRL_TRAP_EN
    logic        illegal;
`endif

    assign legal  = alu_legal(bus.op[5], bus.funct3, bus.funct7);
    assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                    (state == S_ALUWB) || (state == S_BRANCH);

    always_comb begin
        nxt = state;
        unique case (state)
            S_FETCH: nxt = S_DECODE;
            S_DECODE: begin
                unique case (bus.op)
                    OP_LOAD,
                    OP_STORE:  nxt = S_MEMADR;
                    OP_RTYPE:  nxt = S_EXECR;
                    OP_ITYPE:  nxt = S_EXECI;
                    OP_BRANCH: nxt = S_BRANCH;
                    OP_JAL:    nxt = S_JAL;
                    OP_LUI:    nxt = S_LUI;
                    default:   nxt = ILL_ST;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_LOAD) nxt = S_MEMREAD;
                else                   nxt = S_MEMWRITE;
            end
            S_MEMREAD:  nxt = S_MEMWB;
            S_MEMWB:    nxt = S_FETCH;
            S_MEMWRITE: nxt = S_FETCH;
            S_EXECR,
            S_EXECI: begin
                if (legal) nxt = S_ALUWB;
                else       nxt = ILL_ST;
            end
            S_ALUWB:  nxt = S_FETCH;
            S_BRANCH: nxt = S_FETCH;
            S_JAL:    nxt = S_ALUWB;
            S_LUI:    nxt = S_ALUWB;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_FETCH;
        endcase
    end

    // run gates the first FETCH to the first clock after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_FETCH;
            run     <= 1'b0;
            ctrl    <= '0;
            instret <= '0;
`ifdef CTRL_TRAP_EN
            illegal <= 1'b0;
`endif
        end else if (!run) begin
            run  <= 1'b1;
            ctrl <= state_ctrl(S_FETCH);
        end else begin
            state <= nxt;
            ctrl  <= state_ctrl(nxt);
            if (retire) instret <= instret + 32'd1;
`ifdef CTRL_TRAP_EN
            if (nxt == S_TRAP) illegal <= 1'b1;
`endif
        end
    end

    always_comb begin
        br_take = 1'b0;
        unique case (bus.funct3)
            3'b000:  br_take = bus.Zero;
            3'b001:  br_take = !bus.Zero;
            default: br_take = 1'b0;
        endcase
    end

    always_comb begin
        imm_src = IMM_I;
        unique case (state)
            S_DECODE: imm_src = IMM_B;
            S_MEMADR: begin
                if (bus.op == OP_STORE) imm_src = IMM_S;
                else                    imm_src = IMM_I;
            end
            S_LUI:   imm_src = IMM_U;
            default: imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_dec (
        .alu_op      (ctrl.alu_op),
        .funct3      (bus.funct3),
        .funct7_5    (bus.funct7[5]),
        .op_5        (bus.op[5]),
        .alu_control (alu_ctl)
    );

    assign bus.PCWrite    = ctrl.pc_write ||
                            ((state == S_BRANCH) && br_take);
    assign bus.AdrSrc     = ctrl.adr_src;
    assign bus.MemWrite   = ctrl.mem_write;
    assign bus.IRWrite    = ctrl.ir_write;
    assign bus.RegWrite   = ctrl.reg_write;
    assign bus.ResultSrc  = ctrl.result_src;
    assign bus.ALUSrcA    = ctrl.alu_src_a;
    assign bus.ALUSrcB    = ctrl.alu_src_b;
    assign bus.ALUControl = alu_ctl;
    assign bus.ImmSrc     = imm_src;
    assign bus.instret    = instret;
`ifdef CTRL_TRAP_EN
    assign bus.illegal    = illegal;
`endif

endmodule
